iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the MultDiv execution lane.
- Produces the 32-bit word driven onto ExResult[3], the divide slot of the writeback OR-select cell.
- Issue is qualified upstream by MultDivEn & DivEn.
- Supports signed/unsigned quotient and remainder (DIV, DIVU, REM, REMU) with RISC-V corner-case results.

Parameters:
BITWIDTH, 32, operand and result width; also the iteration count.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  issue request, sampled only in IDLE.
- Op  input  2  operation: DIV=0, DIVU=1, REM=2, REMU=3.
- OpA  input  BITWIDTH  dividend.
- OpB  input  BITWIDTH  divisor.
- Flush  input  1  synchronous abort from the pipeline (branch or exception).
- Busy  output  1  high from the cycle after Start is accepted until Done, inclusive of the FIX cycle.
- Done  output  1  one-cycle pulse; Result valid in this cycle.
- Result  output  BITWIDTH  quotient or remainder; held until the next accepted Start.

Behaviour:
- Reset (Rst=1 at an edge, including mid-operation): state=IDLE, Busy=0, Done=0, Result=0, counter=0, internal partial remainder and quotient cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start=1 and Flush=0: latch Op, sign flags, |OpA|, |OpB| (two's-complement magnitude for signed ops only), counter=BITWIDTH-1, then go to CALC.
  - If OpB==0 or signed overflow (OpA==0x80000000 and OpB==0xFFFFFFFF for DIV/REM): latch a special flag and go directly to FIX.
- CALC:
  - Each cycle: shift {rem,quo} left 1; trial subtract divisor from rem (BITWIDTH+1-bit subtractor). Non-negative: keep the difference and set quo LSB=1. Otherwise restore.
  - After BITWIDTH cycles (counter reaches 0), go to FIX.
- FIX:
  - Quotient is negated when dividend and divisor signs differ (signed ops only). Remainder takes the dividend's sign.
  - Select quotient or remainder per Op, register into Result, assert Done for exactly one cycle, return to IDLE.
- Special results:
  - Divide by zero: quotient=all ones, remainder=OpA.
  - Signed overflow: quotient=0x80000000, remainder=0.
- Latency, with Start accepted at edge E0:
  - Normal: Done=1 in the cycle after edge E0+BITWIDTH+1 (34 cycles for BITWIDTH=32).
  - Special: Done=1 after edge E0+1.
- Start while Busy=1: ignored, no queueing.
- Start asserted in the same cycle as Done: accepted, since the state is already IDLE in that cycle's next-state logic. Back-to-back issue is legal.
- Flush:
  - In CALC or FIX: next state IDLE, Busy=0, Done never asserted for that operation, Result unchanged.
  - Flush and Start in the same cycle: Flush wins and Start is dropped.
- Result must not change except at the Done edge or on reset.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |OpA| < |OpB| (unsigned compare of magnitudes, divisor non-zero), skip CALC and go to FIX with quotient=0 and remainder=dividend. Latency matches the special-case path (Done after E0+1).
- Undefined: all non-special operations take the full BITWIDTH CALC cycles.
- Results are identical with or without the macro; only latency differs.

Decomposition:
- Shared package div_pkg holds:
  - typedef enum DivOp_t {DIV, DIVU, REM, REMU}.
  - typedef enum DivState_t {IDLE, CALC, FIX}.
  - Constants DIV_ZERO_QUO (all ones) and INT_MIN (0x80000000).
- One combinational sub-module, div_sign_fix: takes raw quotient/remainder, sign flags, special flag and Op; returns the final Result word. Shared by the normal, special and early-out paths.

Test Plan:
- DIVU 100/7, then REMU 100/7 back-to-back (Start in the Done cycle) -> Result 14 then 2. Done 34 cycles after each Start, Busy high in between.
- DIV -7/2 (0xFFFFFFF9, 2) and REM same operands -> 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1).
- DIVU 5/0 and REMU 5/0 -> 0xFFFFFFFF and 5, Done 2 cycles after Start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIVU 1000/3, Flush 10 cycles after Start -> no Done, Busy 0 next cycle, Result retains prior 14. New Start DIVU 9/3 -> 3 after 34 cycles.
- Start pulsed every cycle while Busy -> only the first operation completes, exactly one Done. Rst asserted mid-CALC -> Busy=0, Done=0, Result=0 after the edge.
- With DIV_EARLY_OUT_EN defined: DIVU 3/10 -> Result 0, Done 2 cycles after Start. REMU 3/10 -> 3. Without the macro: same values, Done at 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the op/state enums and the RISC-V corner-case result words.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } DivOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } DivState_t;

    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

endpackage

// File: rtl/iter_div_unit_if.sv
// Issue/result bundle between the MultDiv lane and the divider.
// Start/Op/OpA/OpB/Flush in; Busy/Done/Result out (slave view).
interface iter_div_unit_if
    import div_pkg::*;
#(
    parameter int BITWIDTH = 32
);
    logic                Start;
    DivOp_t              Op;
    logic [BITWIDTH-1:0] OpA;
    logic [BITWIDTH-1:0] OpB;
    logic                Flush;
    logic                Busy;
    logic                Done;
    logic [BITWIDTH-1:0] Result;

    modport master (
        output Start, Op, OpA, OpB, Flush,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Op, OpA, OpB, Flush,
        output Busy, Done, Result
    );
endinterface

// File: rtl/div_sign_fix.sv
// Final sign correction and quotient/remainder select.
// i_quo/i_rem raw magnitudes, i_neg_a/i_neg_b operand signs,
// i_special bypasses correction, o_result is the result word.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  DivOp_t              i_op,
    input  logic [BITWIDTH-1:0] i_quo,
    input  logic [BITWIDTH-1:0] i_rem,
    input  logic                i_neg_a,
    input  logic                i_neg_b,
    input  logic                i_special,
    output logic [BITWIDTH-1:0] o_result
);
    logic [BITWIDTH-1:0] w_quo;
    logic [BITWIDTH-1:0] w_rem;
    logic                w_is_rem;

    // Special-case words are stored already final.
    always_comb begin
        w_quo = i_quo;
        w_rem = i_rem;
        if (!i_special && (i_neg_a ^ i_neg_b))
            w_quo = -i_quo;
        if (!i_special && i_neg_a)
            w_rem = -i_rem;
    end

    assign w_is_rem = (i_op == REM) || (i_op == REMU);
    assign o_result = w_is_rem ? w_rem : w_quo;
endmodule

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU), BITWIDTH cycles.
// Ports: Clk, Rst (sync, active high), bus (slave view of
// iter_div_unit_if). Optional macro DIV_EARLY_OUT_EN skips the
// iteration when |OpA| < |OpB|.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    iter_div_unit_if.slave bus
);
    localparam int CW = $clog2(BITWIDTH);
    localparam logic [BITWIDTH-1:0] W_MIN =
        {1'b1, {(BITWIDTH-1){1'b0}}};

    DivState_t           r_state;
    DivState_t           w_next;
    DivOp_t              r_op;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_special;
    logic [BITWIDTH-1:0] r_div;
    logic [BITWIDTH-1:0] r_rem;
    logic [BITWIDTH-1:0] r_quo;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    logic [BITWIDTH-1:0] r_result;

    logic                w_signed;
    logic                w_sa;
    logic                w_sb;
    logic [BITWIDTH-1:0] w_mag_a;
    logic [BITWIDTH-1:0] w_mag_b;
    logic                w_dz;
    logic                w_ovf;
    logic                w_special;
    logic                w_early;
    logic                w_accept;
    logic [BITWIDTH:0]   w_rem_sh;
    logic [BITWIDTH+1:0] w_diff;
    logic                w_ge;
    logic [BITWIDTH-1:0] w_fixed;

    assign w_signed = (bus.Op == DIV) || (bus.Op == REM);
    assign w_sa     = w_signed & bus.OpA[BITWIDTH-1];
    assign w_sb     = w_signed & bus.OpB[BITWIDTH-1];
    assign w_mag_a  = w_sa ? -bus.OpA : bus.OpA;
    assign w_mag_b  = w_sb ? -bus.OpB : bus.OpB;
    assign w_dz     = (bus.OpB == '0);
    assign w_ovf    = w_signed && (bus.OpA == W_MIN)
                      && (bus.OpB == '1);
    assign w_special = w_dz | w_ovf;
    assign w_accept  = (r_state == IDLE) && bus.Start
                       && !bus.Flush;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_mag_a < w_mag_b);
`else
    assign w_early = 1'b0;
`endif

    // Shifted remainder can reach 2*divisor-1, so it needs an
    // extra bit; the extra top bit of w_diff is the borrow.
    assign w_rem_sh = {r_rem, r_quo[BITWIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_div};
    assign w_ge     = ~w_diff[BITWIDTH+1];

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next = (w_special || w_early) ? FIX : CALC;
            end
            CALC: begin
                if (bus.Flush)        w_next = IDLE;
                else if (r_cnt == '0) w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_op      <= DIV;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_special <= 1'b0;
            r_div     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.Op;
                        r_div <= w_mag_b;
                        r_cnt <= CW'(BITWIDTH-1);
                        if (w_special) begin
                            // Store final words; sign fix bypassed.
                            r_special <= 1'b1;
                            r_neg_a   <= 1'b0;
                            r_neg_b   <= 1'b0;
                            r_quo     <= w_dz ? '1 : W_MIN;
                            r_rem     <= w_dz ? bus.OpA : '0;
                        end else begin
                            r_special <= 1'b0;
                            r_neg_a   <= w_sa;
                            r_neg_b   <= w_sb;
                            r_quo     <= w_early ? '0 : w_mag_a;
                            r_rem     <= w_early ? w_mag_a : '0;
                        end
                    end
                end
                CALC: begin
                    if (!bus.Flush) begin
                        r_cnt <= r_cnt - 1'b1;
                        r_quo <= {r_quo[BITWIDTH-2:0], w_ge};
                        r_rem <= w_ge ? w_diff[BITWIDTH-1:0]
                                      : w_rem_sh[BITWIDTH-1:0];
                    end
                end
                FIX: begin
                    if (!bus.Flush) begin
                        r_result <= w_fixed;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    div_sign_fix #(.BITWIDTH(BITWIDTH)) u_fix (
        .i_op      (r_op),
        .i_quo     (r_quo),
        .i_rem     (r_rem),
        .i_neg_a   (r_neg_a),
        .i_neg_b   (r_neg_b),
        .i_special (r_special),
        .o_result  (w_fixed)
    );

    assign bus.Busy   = (r_state != IDLE);
    assign bus.Done   = r_done;
    assign bus.Result = r_result;
endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit.
// Latency expectations follow DIV_EARLY_OUT_EN when defined.
module tb_iter_div_unit;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    logic Clk = 1'b0;
    logic Rst;
    int   nvec = 0;
    int   nerr = 0;

    always #5 Clk = ~Clk;

    iter_div_unit_if #(.BITWIDTH(32)) bus ();

    iter_div_unit #(.BITWIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic issue(input DivOp_t op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Latency counts the Start cycle as cycle 0.
    task automatic run(input string tag,
                       input DivOp_t op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp_res,
                       input int exp_lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        issue(op, a, b);
        chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        while (!got && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            if (bus.Done) got = 1'b1;
        end
        chk({tag, "_lat"}, got ? 32'(n + 1) : 32'd0,
            32'(exp_lat));
        chk({tag, "_res"}, bus.Result, exp_res);
    endtask

    initial begin
        int dones;
        logic [31:0] seen;
        Rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.Op    = DIVU;
        bus.OpA   = '0;
        bus.OpB   = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_res", bus.Result, 32'd0);
        Rst = 1'b0;

        // Back-to-back issues, each Start lands in the Done cycle.
        run("divu100_7", DIVU, 32'd100, 32'd7, 32'd14, 34);
        run("remu100_7", REMU, 32'd100, 32'd7, 32'd2, 34);
        run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 34);
        run("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 34);
        run("divu_big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001,
            32'd1, 34);
        run("remu_big", REMU, 32'hFFFF_FFFF, 32'h8000_0001,
            32'h7FFF_FFFE, 34);
        run("div_min_2", DIV, 32'h8000_0000, 32'd2,
            32'hC000_0000, 34);

        run("divu5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run("remu5_0", REMU, 32'd5, 32'd0, 32'd5, 2);
        run("div_m7_0", DIV, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFFF, 2);
        run("rem_m7_0", REM, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFF9, 2);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 2);
        run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 2);

        run("divu3_10", DIVU, 32'd3, 32'd10, 32'd0, EO_LAT);
        run("remu3_10", REMU, 32'd3, 32'd10, 32'd3, EO_LAT);
        run("div_m3_10", DIV, 32'hFFFF_FFFD, 32'd10,
            32'd0, EO_LAT);
        run("rem_m3_10", REM, 32'hFFFF_FFFD, 32'd10,
            32'hFFFF_FFFD, EO_LAT);

        // Flush mid-CALC keeps the previous Result.
        run("divu100_7b", DIVU, 32'd100, 32'd7, 32'd14, 34);
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        bus.Flush = 1'b1;
        @(posedge Clk);
        #1;
        bus.Flush = 1'b0;
        chk("flush_busy", 32'(bus.Busy), 32'd0);
        chk("flush_done", 32'(bus.Done), 32'd0);
        chk("flush_res", bus.Result, 32'd14);
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            dones += int'(bus.Done);
        end
        chk("flush_nodone", 32'(dones), 32'd0);
        chk("flush_hold", bus.Result, 32'd14);
        run("divu9_3", DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Flush beats Start in the same cycle.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.Op    = DIVU;
        bus.OpA   = 32'd50;
        bus.OpB   = 32'd5;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        chk("fs_busy", 32'(bus.Busy), 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            dones += int'(bus.Done);
        end
        chk("fs_nodone", 32'(dones), 32'd0);
        chk("fs_hold", bus.Result, 32'd3);

        // Start held every cycle while Busy: only one op runs.
        issue(DIVU, 32'd20, 32'd4);
        bus.Op  = DIVU;
        bus.OpA = 32'd99;
        bus.OpB = 32'd1;
        dones = 0;
        seen  = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            if (bus.Done) begin
                dones++;
                seen = bus.Result;
            end
            bus.Start = bus.Busy;
        end
        bus.Start = 1'b0;
        chk("hold_ndone", 32'(dones), 32'd1);
        chk("hold_res", seen, 32'd5);
        chk("hold_idle", 32'(bus.Busy), 32'd0);

        // Reset in the middle of CALC.
        issue(DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("mrst_busy", 32'(bus.Busy), 32'd0);
        chk("mrst_done", 32'(bus.Done), 32'd0);
        chk("mrst_res", bus.Result, 32'd0);
        Rst = 1'b0;
        run("post_rst", DIVU, 32'd1000, 32'd3, 32'd333, 34);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end
endmodule
